alu_branch_unit: RTL and testbench

- Registered execute-stage datapath slice for the 32-bit pipelined CPU.
- Combines three functions:
  - Integer ALU with 4-bit opcode.
  - Branch-target adder: PC+4 plus the word-shifted immediate.
  - Branch-decision AND gate: BRANCH & (A == B).
- All results are registered with one-cycle latency and qualified by a valid bit.

---
 rtl/alu_branch_unit.sv | 141 ++++++++++++++
 tb/tb_alu_branch_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_branch_unit.sv
// Registered execute-stage slice: integer ALU, branch-target adder and branch decision.
// Optional multiplier on opcode 12 is enabled by defining ALU_MUL_EN.
module alu_branch_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] SRC_A,
    input  logic [WIDTH-1:0] SRC_B,
    input  logic [3:0]       ALU_CONTROL,
    input  logic             BRANCH,
    input  logic [WIDTH-1:0] PC_PLUS4,
    input  logic [WIDTH-1:0] SIGN_IMM,
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             ZERO,
    output logic             CARRY,
    output logic [WIDTH-1:0] BR_TARGET,
    output logic             PC_SRC
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_NOR    = 4'd5;
    localparam logic [3:0] OP_SLL    = 4'd6;
    localparam logic [3:0] OP_SRL    = 4'd7;
    localparam logic [3:0] OP_SRA    = 4'd8;
    localparam logic [3:0] OP_SLT    = 4'd9;
    localparam logic [3:0] OP_SLTU   = 4'd10;
    localparam logic [3:0] OP_PASS_B = 4'd11;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL    = 4'd12;
`endif

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sra_res;
    logic             slt_bit;
    logic             sltu_bit;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [WIDTH-1:0] target;
    logic             equal;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mul_res;
    assign mul_res = SRC_A * SRC_B;
`endif

    logic             valid_q,  valid_d;
    logic [WIDTH-1:0] alu_q,    alu_d;
    logic             zero_q,   zero_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             pcsrc_q,  pcsrc_d;

    // Subtraction as A + ~B + 1 so the carry-out is the unsigned "no borrow" flag.
    assign add_sum  = {1'b0, SRC_A} + {1'b0, SRC_B};
    assign sub_sum  = {1'b0, SRC_A} + {1'b0, ~SRC_B} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt    = SRC_B[SHW-1:0];
    assign sra_res  = $signed(SRC_A) >>> shamt;
    assign slt_bit  = $signed(SRC_A) < $signed(SRC_B);
    assign sltu_bit = SRC_A < SRC_B;
    assign equal    = (SRC_A == SRC_B);
    assign target   = PC_PLUS4 + (SIGN_IMM << 2);

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (ALU_CONTROL)
            OP_ADD: begin
                alu_res   = add_sum[WIDTH-1:0];
                alu_carry = add_sum[WIDTH];
            end
            OP_SUB: begin
                alu_res   = sub_sum[WIDTH-1:0];
                alu_carry = sub_sum[WIDTH];
            end
            OP_AND:    alu_res = SRC_A & SRC_B;
            OP_OR:     alu_res = SRC_A | SRC_B;
            OP_XOR:    alu_res = SRC_A ^ SRC_B;
            OP_NOR:    alu_res = ~(SRC_A | SRC_B);
            OP_SLL:    alu_res = SRC_A << shamt;
            OP_SRL:    alu_res = SRC_A >> shamt;
            OP_SRA:    alu_res = sra_res;
            OP_SLT:    alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_SLTU:   alu_res = {{(WIDTH-1){1'b0}}, sltu_bit};
            OP_PASS_B: alu_res = SRC_B;
`ifdef ALU_MUL_EN
            OP_MUL:    alu_res = mul_res;
`endif
            default:   alu_res = '0;
        endcase
    end

    // Result registers hold when idle; valid and branch-taken never do.
    always_comb begin
        valid_d  = IN_VALID;
        pcsrc_d  = IN_VALID & BRANCH & equal;
        alu_d    = alu_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        target_d = target_q;
        if (IN_VALID) begin
            alu_d    = alu_res;
            zero_d   = (alu_res == '0);
            carry_d  = alu_carry;
            target_d = target;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_q  <= 1'b0;
            alu_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            target_q <= '0;
            pcsrc_q  <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            alu_q    <= alu_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            target_q <= target_d;
            pcsrc_q  <= pcsrc_d;
        end
    end

    assign OUT_VALID = valid_q;
    assign ALU_OUT   = alu_q;
    assign ZERO      = zero_q;
    assign CARRY     = carry_q;
    assign BR_TARGET = target_q;
    assign PC_SRC    = pcsrc_q;
endmodule

// File: tb/tb_alu_branch_unit.sv
// Directed table-driven bench for alu_branch_unit, plus reset and valid-gating sequences.
module tb_alu_branch_unit;
    localparam int W = 32;

    logic         CLK;
    logic         RESET;
    logic         IN_VALID;
    logic [W-1:0] SRC_A;
    logic [W-1:0] SRC_B;
    logic [3:0]   ALU_CONTROL;
    logic         BRANCH;
    logic [W-1:0] PC_PLUS4;
    logic [W-1:0] SIGN_IMM;
    logic         OUT_VALID;
    logic [W-1:0] ALU_OUT;
    logic         ZERO;
    logic         CARRY;
    logic [W-1:0] BR_TARGET;
    logic         PC_SRC;

    int total = 0;
    int bad   = 0;

    alu_branch_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID),
        .SRC_A(SRC_A), .SRC_B(SRC_B), .ALU_CONTROL(ALU_CONTROL),
        .BRANCH(BRANCH), .PC_PLUS4(PC_PLUS4), .SIGN_IMM(SIGN_IMM),
        .OUT_VALID(OUT_VALID), .ALU_OUT(ALU_OUT), .ZERO(ZERO), .CARRY(CARRY),
        .BR_TARGET(BR_TARGET), .PC_SRC(PC_SRC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         br;
        logic [W-1:0] pc;
        logic [W-1:0] imm;
        logic [W-1:0] e_alu;
        logic         e_zero;
        logic         e_carry;
        logic [W-1:0] e_tgt;
        logic         e_pcsrc;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    function automatic vec_t mk(string n, logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b,
                                logic br, logic [W-1:0] pc, logic [W-1:0] imm,
                                logic [W-1:0] e_alu, logic e_zero, logic e_carry,
                                logic [W-1:0] e_tgt, logic e_pcsrc);
        vec_t v;
        v.name = n; v.op = op; v.a = a; v.b = b; v.br = br; v.pc = pc; v.imm = imm;
        v.e_alu = e_alu; v.e_zero = e_zero; v.e_carry = e_carry;
        v.e_tgt = e_tgt; v.e_pcsrc = e_pcsrc;
        return v;
    endfunction

    task automatic chk(string n, logic [W-1:0] act, logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", n, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b,
                         logic br, logic [W-1:0] pc, logic [W-1:0] imm);
        IN_VALID = v; ALU_CONTROL = op; SRC_A = a; SRC_B = b;
        BRANCH = br; PC_PLUS4 = pc; SIGN_IMM = imm;
    endtask

    task automatic chk_all_zero(string n);
        chk({n, ".valid"}, {31'd0, OUT_VALID}, 32'd0);
        chk({n, ".alu"},   ALU_OUT, 32'd0);
        chk({n, ".zero"},  {31'd0, ZERO}, 32'd0);
        chk({n, ".carry"}, {31'd0, CARRY}, 32'd0);
        chk({n, ".tgt"},   BR_TARGET, 32'd0);
        chk({n, ".pcsrc"}, {31'd0, PC_SRC}, 32'd0);
    endtask

    initial begin
`ifdef ALU_MUL_EN
        logic [W-1:0] mul_exp = 32'd42;
        logic         mul_z   = 1'b0;
`else
        logic [W-1:0] mul_exp = 32'd0;
        logic         mul_z   = 1'b1;
`endif
        vecs[0]  = mk("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 0, 32'h100, 0, 32'h0, 1, 1, 32'h100, 0);
        vecs[1]  = mk("sub_5_7",  4'd1, 32'd5, 32'd7, 0, 32'h100, 0, 32'hFFFF_FFFE, 0, 0, 32'h100, 0);
        vecs[2]  = mk("sub_7_5",  4'd1, 32'd7, 32'd5, 0, 32'h100, 0, 32'h2, 0, 1, 32'h100, 0);
        vecs[3]  = mk("sub_5_5",  4'd1, 32'd5, 32'd5, 0, 32'h100, 0, 32'h0, 1, 1, 32'h100, 0);
        vecs[4]  = mk("slt",      4'd9, 32'h8000_0000, 32'h1, 0, 32'h100, 0, 32'h1, 0, 0, 32'h100, 0);
        vecs[5]  = mk("sltu",     4'd10, 32'h8000_0000, 32'h1, 0, 32'h100, 0, 32'h0, 1, 0, 32'h100, 0);
        vecs[6]  = mk("sra",      4'd8, 32'h8000_0000, 32'h21, 0, 32'h100, 0, 32'hC000_0000, 0, 0, 32'h100, 0);
        vecs[7]  = mk("srl",      4'd7, 32'h8000_0000, 32'h21, 0, 32'h100, 0, 32'h4000_0000, 0, 0, 32'h100, 0);
        vecs[8]  = mk("sll",      4'd6, 32'h1, 32'd31, 0, 32'h100, 0, 32'h8000_0000, 0, 0, 32'h100, 0);
        vecs[9]  = mk("and",      4'd2, 32'hF0F0, 32'hFF00, 0, 32'h100, 0, 32'hF000, 0, 0, 32'h100, 0);
        vecs[10] = mk("or",       4'd3, 32'hF0F0, 32'hFF00, 0, 32'h100, 0, 32'hFFF0, 0, 0, 32'h100, 0);
        vecs[11] = mk("xor",      4'd4, 32'hF0F0, 32'hFF00, 0, 32'h100, 0, 32'h0FF0, 0, 0, 32'h100, 0);
        vecs[12] = mk("nor",      4'd5, 32'hF0F0, 32'hFF00, 0, 32'h100, 0, 32'hFFFF_000F, 0, 0, 32'h100, 0);
        vecs[13] = mk("pass_b",   4'd11, 32'h9, 32'h1234, 0, 32'h100, 0, 32'h1234, 0, 0, 32'h100, 0);
        vecs[14] = mk("op12",     4'd12, 32'd6, 32'd7, 0, 32'h100, 0, mul_exp, mul_z, 0, 32'h100, 0);
        vecs[15] = mk("op13",     4'd13, 32'd6, 32'd7, 0, 32'h100, 0, 32'h0, 1, 0, 32'h100, 0);
        vecs[16] = mk("op14",     4'd14, 32'd6, 32'd7, 0, 32'h100, 0, 32'h0, 1, 0, 32'h100, 0);
        vecs[17] = mk("op15",     4'd15, 32'd6, 32'd7, 0, 32'h100, 0, 32'h0, 1, 0, 32'h100, 0);
        vecs[18] = mk("br_taken", 4'd0, 32'h55, 32'h55, 1, 32'h100, 32'hFFFF_FFFE, 32'hAA, 0, 0, 32'hF8, 1);
        vecs[19] = mk("br_neq",   4'd0, 32'h55, 32'h56, 1, 32'h100, 32'hFFFF_FFFE, 32'hAB, 0, 0, 32'hF8, 0);
        vecs[20] = mk("nobr_eq",  4'd0, 32'h55, 32'h55, 0, 32'h200, 32'h3, 32'hAA, 0, 0, 32'h20C, 0);

        RESET = 1'b1;
        drive(0, 4'd0, 0, 0, 0, 0, 0);
        #1;
        chk_all_zero("por");
        @(negedge CLK);
        chk_all_zero("por_edge");
        RESET = 1'b0;

        drive(1, 4'd0, 32'd3, 32'd4, 0, 32'h100, 0);
        @(negedge CLK);
        chk("first_add.alu", ALU_OUT, 32'd7);
        chk("first_add.valid", {31'd0, OUT_VALID}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            drive(1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].br, vecs[i].pc, vecs[i].imm);
            @(negedge CLK);
            $display("vec %0d %s: alu=0x%08h z=%0b c=%0b tgt=0x%08h pcsrc=%0b",
                     i, vecs[i].name, ALU_OUT, ZERO, CARRY, BR_TARGET, PC_SRC);
            chk({vecs[i].name, ".valid"}, {31'd0, OUT_VALID}, 32'd1);
            chk({vecs[i].name, ".alu"},   ALU_OUT, vecs[i].e_alu);
            chk({vecs[i].name, ".zero"},  {31'd0, ZERO}, {31'd0, vecs[i].e_zero});
            chk({vecs[i].name, ".carry"}, {31'd0, CARRY}, {31'd0, vecs[i].e_carry});
            chk({vecs[i].name, ".tgt"},   BR_TARGET, vecs[i].e_tgt);
            chk({vecs[i].name, ".pcsrc"}, {31'd0, PC_SRC}, {31'd0, vecs[i].e_pcsrc});
        end

        // Valid gating: results hold, valid and branch decision drop.
        drive(1, 4'd2, 32'hF0F0, 32'hFF00, 0, 32'h100, 0);
        @(negedge CLK);
        chk("gate_and.alu", ALU_OUT, 32'hF000);
        drive(0, 4'd0, 32'h77, 32'h77, 1, 32'h400, 32'h10);
        @(negedge CLK);
        $display("gate idle: alu=0x%08h valid=%0b pcsrc=%0b", ALU_OUT, OUT_VALID, PC_SRC);
        chk("gate_idle.alu",   ALU_OUT, 32'hF000);
        chk("gate_idle.valid", {31'd0, OUT_VALID}, 32'd0);
        chk("gate_idle.pcsrc", {31'd0, PC_SRC}, 32'd0);
        chk("gate_idle.tgt",   BR_TARGET, 32'h100);
        chk("gate_idle.zero",  {31'd0, ZERO}, 32'd0);

        // Build nonzero state, then reset mid-cycle with no clock edge in between.
        drive(1, 4'd0, 32'hFFFF_FFFF, 32'h2, 1, 32'h100, 32'hFFFF_FFFE);
        @(negedge CLK);
        drive(1, 4'd0, 32'h9, 32'h9, 1, 32'h100, 32'h1);
        #2;
        RESET = 1'b1;
        #1;
        $display("mid-cycle reset: alu=0x%08h valid=%0b", ALU_OUT, OUT_VALID);
        chk_all_zero("async_rst");
        @(negedge CLK);
        chk_all_zero("rst_held");
        RESET = 1'b0;
        drive(1, 4'd0, 32'd3, 32'd4, 0, 32'h100, 0);
        @(negedge CLK);
        $display("post reset add: alu=0x%08h valid=%0b", ALU_OUT, OUT_VALID);
        chk("post_rst.alu",   ALU_OUT, 32'd7);
        chk("post_rst.valid", {31'd0, OUT_VALID}, 32'd1);
        chk("post_rst.tgt",   BR_TARGET, 32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
